// File: rtl/activity_led_ctrl.sv
// Activity indicator for the board test LED: per-channel synchronizer and
// pulse stretcher, OR-combined into an off/direct/stretched/blink LED with PWM.
module activity_led_ctrl #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned STRETCH_BITS = 22,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned BLINK_BITS   = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] act_n,
  input  logic [CHANNELS-1:0] chan_enable,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [CHANNELS-1:0] busy,
  output logic                led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_DIRECT  = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_BLINK   = 2'b11
  } led_mode_t;

  logic [CHANNELS-1:0]     sync1, sync2;
  logic [CHANNELS-1:0]     act_s;
  logic [CHANNELS-1:0]     busy_next;
  logic [STRETCH_BITS-1:0] cnt      [CHANNELS];
  logic [STRETCH_BITS-1:0] cnt_next [CHANNELS];
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic [BLINK_BITS-1:0]   blink_cnt;
  logic                    pwm_on, blink_on, source;

  assign act_s = ~sync2 & chan_enable;

  // busy is registered from the counter's next state so it rises together
  // with the counter clear rather than one clock after it.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_next[i] = cnt[i];
      if (!chan_enable[i])
        cnt_next[i] = '1;
      else if (act_s[i])
        cnt_next[i] = '0;
      else if (!cnt[i][STRETCH_BITS-1])
        cnt_next[i] = cnt[i] + STRETCH_BITS'(1);
      busy_next[i] = ~cnt_next[i][STRETCH_BITS-1];
    end
  end

  assign pwm_on   = (brightness == '1) || (pwm_cnt < brightness);
  assign blink_on = ~blink_cnt[BLINK_BITS-1];

  always_comb begin
    source = 1'b0;
    case (led_mode_t'(mode))
      MODE_OFF:     source = 1'b0;
      MODE_DIRECT:  source = |act_s;
      MODE_STRETCH: source = |busy;
      MODE_BLINK:   source = (|busy) & blink_on;
      default:      source = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '1;
      sync2     <= '1;
      busy      <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      led       <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++)
        cnt[i] <= '1;
    end else begin
      sync1     <= act_n;
      sync2     <= sync1;
      busy      <= busy_next;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
      led       <= source & pwm_on;
      for (int unsigned i = 0; i < CHANNELS; i++)
        cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_activity_led_ctrl.sv
// Directed bench for activity_led_ctrl with small counters (stretch 8, PWM 4, blink 8).
module tb_activity_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] act_n;
  logic [1:0] chan_enable;
  logic [1:0] mode;
  logic [1:0] brightness;
  logic [1:0] busy;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int highs;

  activity_led_ctrl #(
    .CHANNELS(2),
    .STRETCH_BITS(4),
    .PWM_BITS(2),
    .BLINK_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .act_n(act_n),
    .chan_enable(chan_enable),
    .mode(mode),
    .brightness(brightness),
    .busy(busy),
    .led(led)
  );

  always #5 clk = ~clk;

  // Edges elapsed since reset release; reference time base for the free-running phases.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; act_n = 2'b00; chan_enable = 2'b11; mode = 2'b10; brightness = 2'd3;

    // Reset held with activity present
    #1;
    check("rst_led_async", {31'd0, led}, 32'd0);
    check("rst_busy_async", {30'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_led", {31'd0, led}, 32'd0);
      check("rst_busy", {30'd0, busy}, 32'd0);
    end
    act_n = 2'b11;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_led", {31'd0, led}, 32'd0);
      check("post_rst_busy", {30'd0, busy}, 32'd0);
    end

    // Single 1-clock pulse on channel 0, stretched mode
    act_n = 2'b10;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) act_n = 2'b11;
      check("s_busy", {30'd0, busy}, (i >= 3 && i <= 10) ? 32'd1 : 32'd0);
      check("s_led", {31'd0, led}, (i >= 4 && i <= 11) ? 32'd1 : 32'd0);
    end

    // Retrigger mid-stretch extends busy
    act_n = 2'b10;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 1 || i == 6) act_n = 2'b11;
      if (i == 5) act_n = 2'b10;
      check("rt_busy", {30'd0, busy}, (i >= 3 && i <= 15) ? 32'd1 : 32'd0);
      check("rt_led", {31'd0, led}, (i >= 4 && i <= 16) ? 32'd1 : 32'd0);
    end

    // Direct mode, channel 1 low for 5 clocks
    mode = 2'b01;
    act_n = 2'b01;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 5) act_n = 2'b11;
      check("d_led", {31'd0, led}, (i >= 3 && i <= 7) ? 32'd1 : 32'd0);
      check("d_busy", {30'd0, busy}, (i >= 3 && i <= 14) ? 32'd2 : 32'd0);
    end

    // PWM duty with channel 0 held active
    mode = 2'b10;
    brightness = 2'd3;
    act_n = 2'b10;
    repeat (5) tick();
    for (int k = 0; k < 4; k++) begin
      int b;
      int exp_high;
      b = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 : 0;
      brightness = 2'(b);
      exp_high = (b == 3) ? 8 : 2 * b;
      tick();
      highs = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (led) highs++;
        check("pwm_phase", {31'd0, led}, (((cyc - 1) & 3) < b || b == 3) ? 32'd1 : 32'd0);
      end
      check("pwm_count", highs, exp_high);
    end

    // Blink: 4 on / 4 off aligned to the blink counter
    brightness = 2'd3;
    mode = 2'b11;
    tick();
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (led) highs++;
      check("blink_phase", {31'd0, led}, (((cyc - 1) & 7) < 4) ? 32'd1 : 32'd0);
    end
    check("blink_count", highs, 8);

    // Disable mid-stretch, then async reset mid-stretch
    act_n = 2'b11;
    mode = 2'b10;
    repeat (14) tick();
    check("idle_busy", {30'd0, busy}, 32'd0);
    act_n = 2'b10;
    tick();
    act_n = 2'b11;
    repeat (4) tick();
    check("pre_dis_busy", {30'd0, busy}, 32'd1);
    chan_enable = 2'b10;
    tick();
    check("dis_busy", {30'd0, busy}, 32'd0);
    check("dis_led_lag", {31'd0, led}, 32'd1);
    tick();
    check("dis_led", {31'd0, led}, 32'd0);
    chan_enable = 2'b11;
    act_n = 2'b10;
    tick();
    act_n = 2'b11;
    repeat (4) tick();
    check("re_busy", {30'd0, busy}, 32'd1);
    check("re_led", {31'd0, led}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_led", {31'd0, led}, 32'd0);
    check("arst_busy", {30'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("arst_idle_led", {31'd0, led}, 32'd0);
      check("arst_idle_busy", {30'd0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
